// File: rtl/i2c_pkg.sv
// Shared types and constants for the WM8731 I2C write master.
package i2c_pkg;

    typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP, DONE} state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int unsigned BITS_PER_BYTE  = 8;
    localparam int unsigned BYTES_PER_XFER = 3;
    localparam int unsigned QTRS_PER_CELL  = 4;

    // Bit bit_idx of byte byte_idx, where byte 0 is the slave address in [23:16].
    function automatic logic xfer_bit(input logic [23:0] data, input logic [1:0] byte_idx,
                                      input logic [2:0] bit_idx);
        logic [23:0] w_sh;
        w_sh = data >> ((BYTES_PER_XFER - 1 - 32'(byte_idx)) * BITS_PER_BYTE + 32'(bit_idx));
        return w_sh[0];
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick generator: one-cycle pulse every QDIV cycles, held at zero by i_hold.
module i2c_tick_gen #(
    parameter int unsigned QDIV = 625
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_hold,
    output logic o_tick
);

    localparam int unsigned CW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST) && !i_hold;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_hold) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_write_master.sv
// Single 3-byte I2C write (address, sub-address, data) with a level GO/END handshake.
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_Freq = 50000000,
    parameter int unsigned I2C_Freq = 20000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [23:0] iDATA,
    input  logic        iGO,
    output logic        oEND,
    output logic        oACK,
    output logic        oBUSY,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT
);

    localparam int unsigned QDIV = CLK_Freq / (4 * I2C_Freq);
    localparam int unsigned QW = $clog2(QTRS_PER_CELL);
    localparam logic [2:0] BIT_MSB = 3'(BITS_PER_BYTE - 1);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_XFER - 1);

    state_e        r_state, w_state;
    logic [QW-1:0] r_qtr, w_qtr;
    logic [2:0]    r_bit, w_bit;
    logic [1:0]    r_byte, w_byte;
    logic [23:0]   r_data, w_data;
    logic          r_nack, w_nack;
    logic          r_scl, w_scl;
    logic          r_sda_oe, w_sda_oe;
    logic          r_busy, w_busy;
    logic          r_end;
    logic          r_sda_meta, r_sda_sync;
    logic          w_tick, w_hold;

    assign w_hold = (r_state == IDLE) || (r_state == DONE);

    i2c_tick_gen #(
        .QDIV(QDIV)
    ) u_tick_gen (
        .i_clk (iCLK),
        .i_rst (iRST),
        .i_hold(w_hold),
        .o_tick(w_tick)
    );

    // Each tick enters the next quarter; the outputs assigned are those of that quarter.
    always_comb begin
        w_state  = r_state;
        w_qtr    = r_qtr;
        w_bit    = r_bit;
        w_byte   = r_byte;
        w_data   = r_data;
        w_nack   = r_nack;
        w_scl    = r_scl;
        w_sda_oe = r_sda_oe;
        unique case (r_state)
            IDLE: begin
                w_scl    = 1'b1;
                w_sda_oe = 1'b0;
                if (iGO) begin
                    w_data  = iDATA;
                    w_nack  = 1'b0;
                    w_qtr   = Q0;
                    w_state = START;
                end
            end
            START: if (w_tick) begin
                w_qtr = r_qtr + 2'd1;
                unique case (r_qtr)
                    Q0: w_scl = 1'b1;
                    Q1: w_sda_oe = 1'b1;
                    Q2: w_scl = 1'b0;
                    Q3: begin
                        w_state  = BYTE;
                        w_byte   = 2'd0;
                        w_bit    = BIT_MSB;
                        w_sda_oe = ~xfer_bit(r_data, 2'd0, BIT_MSB);
                    end
                endcase
            end
            BYTE: if (w_tick) begin
                w_qtr = r_qtr + 2'd1;
                unique case (r_qtr)
                    Q0: w_scl = 1'b0;
                    Q1: w_scl = 1'b1;
                    Q2: w_scl = 1'b1;
                    Q3: begin
                        w_scl = 1'b0;
                        if (r_bit == 3'd0) begin
                            w_state  = ACK;
                            w_sda_oe = 1'b0;
                        end else begin
                            w_bit    = r_bit - 3'd1;
                            w_sda_oe = ~xfer_bit(r_data, r_byte, r_bit - 3'd1);
                        end
                    end
                endcase
            end
            ACK: if (w_tick) begin
                w_qtr = r_qtr + 2'd1;
                unique case (r_qtr)
                    Q0: w_scl = 1'b0;
                    Q1: w_scl = 1'b1;
                    Q2: if (r_sda_sync) w_nack = 1'b1;
                    Q3: begin
                        w_scl = 1'b0;
                        if (r_nack || (r_byte == LAST_BYTE)) begin
                            w_state  = STOP;
                            w_sda_oe = 1'b1;
                        end else begin
                            w_state  = BYTE;
                            w_byte   = r_byte + 2'd1;
                            w_bit    = BIT_MSB;
                            w_sda_oe = ~xfer_bit(r_data, r_byte + 2'd1, BIT_MSB);
                        end
                    end
                endcase
            end
            STOP: if (w_tick) begin
                w_qtr = r_qtr + 2'd1;
                unique case (r_qtr)
                    Q0: w_scl = 1'b1;
                    Q1: w_sda_oe = 1'b0;
                    Q2: w_sda_oe = 1'b0;
                    Q3: w_state = DONE;
                endcase
            end
            DONE: if (!iGO) w_state = IDLE;
            default: w_state = IDLE;
        endcase
        w_busy = (w_state != IDLE) && (w_state != DONE);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state    <= IDLE;
            r_qtr      <= Q0;
            r_bit      <= 3'd0;
            r_byte     <= 2'd0;
            r_data     <= '0;
            r_nack     <= 1'b0;
            r_scl      <= 1'b1;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_end      <= 1'b0;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_qtr      <= w_qtr;
            r_bit      <= w_bit;
            r_byte     <= w_byte;
            r_data     <= w_data;
            r_nack     <= w_nack;
            r_scl      <= w_scl;
            r_sda_oe   <= w_sda_oe;
            r_busy     <= w_busy;
            r_end      <= (r_state == DONE);
            r_sda_meta <= I2C_SDAT;
            r_sda_sync <= r_sda_meta;
        end
    end

    assign I2C_SDAT = r_sda_oe ? 1'b0 : 1'bz;
    assign I2C_SCLK = r_scl;
    assign oEND     = r_end;
    assign oACK     = r_nack;
    assign oBUSY    = r_busy;

endmodule

// File: tb/tb_i2c_write_master.sv
// Scoreboard bench: stimulus queues expected frames/results, a negedge monitor decodes the bus.
module tb_i2c_write_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] idata = '0;
    logic        igo = 1'b0;
    logic        o_end, o_ack, o_busy, scl;
    wire         sda_bus;
    logic        sl_pull = 1'b0;

    pullup (sda_bus);
    assign sda_bus = sl_pull ? 1'b0 : 1'bz;

    i2c_write_master #(
        .CLK_Freq(400),
        .I2C_Freq(25)
    ) dut (
        .iCLK    (clk),
        .iRST    (rst),
        .iDATA   (idata),
        .iGO     (igo),
        .oEND    (o_end),
        .oACK    (o_ack),
        .oBUSY   (o_busy),
        .I2C_SCLK(scl),
        .I2C_SDAT(sda_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [26:0] bits;
        int          nbits;
        logic        ack;
        int          lat;
        int          width;
        int          nack_byte;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [26:0] b, input int n, input logic a, input int l,
                                input int w, input int nb);
        exp_t e;
        e.bits = b;
        e.nbits = n;
        e.ack = a;
        e.lat = l;
        e.width = w;
        e.nack_byte = nb;
        return e;
    endfunction

    // Bus decoder, slave model and completion monitor.
    logic        p_scl = 1'b1, p_sda = 1'b1, p_end = 1'b0;
    bit          in_txn = 1'b0;
    logic [26:0] got_bits = '0;
    int          got_n = 0;
    int          acc_cyc = 0, rise_cyc = 0, pend_w = -1;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            in_txn = 1'b0;
            got_n = 0;
            got_bits = '0;
            sl_pull = 1'b0;
            pend_w = -1;
        end else begin
            if (sl_pull) chk("sda_not_driven_high", sda_bus, 0);
            if (scl && p_scl && (sda_bus !== p_sda)) begin
                if (!sda_bus) begin
                    chk("start_expected", (!in_txn && exp_q.size() > 0), 1);
                    in_txn = 1'b1;
                    got_n = 0;
                    got_bits = '0;
                end else begin
                    chk("stop_in_txn", in_txn, 1);
                    // The SCL rise of the stop sequence was recorded as a bit; drop it.
                    if (in_txn && exp_q.size() > 0) begin
                        chk("frame_len", got_n - 1, exp_q[0].nbits);
                        chk("frame_bits", got_bits >> 1, exp_q[0].bits);
                    end
                    in_txn = 1'b0;
                end
            end else if (scl && !p_scl && in_txn) begin
                got_bits = {got_bits[25:0], sda_bus};
                got_n++;
            end
            if (!scl && p_scl && in_txn) begin
                sl_pull = (got_n % 9 == 8) &&
                          ((got_n / 9) != ((exp_q.size() > 0) ? exp_q[0].nack_byte : -1));
            end
            if (o_end && !p_end) begin
                rise_cyc = cyc;
                chk("busy_low_at_end", o_busy, 0);
                if (exp_q.size() == 0) begin
                    chk("end_expected", exp_q.size(), 1);
                end else begin
                    chk("ack_flag", o_ack, exp_q[0].ack);
                    chk("latency", cyc - acc_cyc, exp_q[0].lat);
                    pend_w = exp_q[0].width;
                    exp_q.delete(0);
                end
            end
            if (!o_end && p_end && pend_w > 0) begin
                chk("end_width", cyc - rise_cyc, pend_w);
                pend_w = -1;
            end
        end
        p_scl = scl;
        p_sda = sda_bus;
        p_end = o_end;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [23:0] d, input exp_t e);
        idata = d;
        exp_q.push_back(e);
        acc_cyc = cyc + 1;
        igo = 1'b1;
    endtask

    task automatic wait_end(input int budget, input string name);
        int k = 0;
        while (!o_end && k < budget) begin
            cycles(1);
            k++;
        end
        chk(name, o_end, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cycles(3);
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda_bus, 1);
        chk("rst_end", o_end, 0);
        chk("rst_ack", o_ack, 0);
        chk("rst_busy", o_busy, 0);
        rst = 1'b0;
        cycles(2);

        // 1: all bytes acknowledged, iGO held until END.
        start_xfer(24'h341201, mk({8'h34, 1'b0, 8'h12, 1'b0, 8'h01, 1'b0}, 27, 1'b0, 465, -1, -1));
        cycles(1);
        chk("t1_busy", o_busy, 1);
        wait_end(600, "t1_done");
        igo = 1'b0;
        cycles(3);
        chk("t1_end_clear", o_end, 0);

        // 2: NACK on byte 1, one-cycle GO pulse.
        start_xfer(24'h341201, mk({9'd0, 8'h34, 1'b0, 8'h12, 1'b1}, 18, 1'b1, 321, 1, 1));
        cycles(1);
        igo = 1'b0;
        wait_end(400, "t2_done");
        cycles(3);
        chk("t2_end_clear", o_end, 0);

        // 3: GO held after completion, then a second transaction.
        start_xfer(24'h341201, mk({8'h34, 1'b0, 8'h12, 1'b0, 8'h01, 1'b0}, 27, 1'b0, 465, -1, -1));
        wait_end(600, "t3_done");
        for (int i = 0; i < 40; i++) begin
            cycles(1);
            chk("t3_end_held", o_end, 1);
            chk("t3_idle_busy", o_busy, 0);
            chk("t3_idle_scl", scl, 1);
        end
        igo = 1'b0;
        cycles(1);
        chk("t3_end_lingers", o_end, 1);
        cycles(1);
        chk("t3_end_clear", o_end, 0);
        start_xfer(24'h340C00, mk({8'h34, 1'b0, 8'h0C, 1'b0, 8'h00, 1'b0}, 27, 1'b0, 465, -1, -1));
        wait_end(600, "t3b_done");
        igo = 1'b0;
        cycles(3);

        // 4: GO pulse with iDATA changing mid-transfer.
        start_xfer(24'h1AA5C3, mk({8'h1A, 1'b0, 8'hA5, 1'b0, 8'hC3, 1'b0}, 27, 1'b0, 465, 1, -1));
        cycles(1);
        igo = 1'b0;
        cycles(20);
        idata = 24'hFFFFFF;
        cycles(100);
        idata = 24'h000000;
        wait_end(600, "t4_done");
        cycles(3);

        // 5: reset during bit 3 of byte 0, then a normal transfer.
        start_xfer(24'h341201, mk('0, 0, 1'b0, 0, -1, -1));
        cycles(1);
        igo = 1'b0;
        cycles(85);
        chk("t5_pre_busy", o_busy, 1);
        chk("t5_pre_scl", scl, 0);
        rst = 1'b1;
        cycles(1);
        chk("t5_rst_scl", scl, 1);
        chk("t5_rst_sda", sda_bus, 1);
        chk("t5_rst_busy", o_busy, 0);
        chk("t5_rst_end", o_end, 0);
        rst = 1'b0;
        exp_q.delete(0);
        cycles(5);
        start_xfer(24'h341201, mk({8'h34, 1'b0, 8'h12, 1'b0, 8'h01, 1'b0}, 27, 1'b0, 465, 1, -1));
        cycles(1);
        igo = 1'b0;
        wait_end(600, "t5_done");
        cycles(10);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
